// File: rtl/qpu_exu_qiu_evq.sv
// QIU event queue: merges decoded quantum instructions that share one
// timepoint into a single event bundle, stamps it with the accumulated
// timestamp and buffers closed bundles in a small FIFO for write-back.
module qpu_exu_qiu_evq #(
  parameter int QUBIT_NUM = 12,
  parameter int OPC_W     = 5,
  parameter int TIME_W    = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       qiu_i_valid,
  output logic                       qiu_i_ready,
  input  logic [QUBIT_NUM-1:0]       qiu_i_rs1,
  input  logic [QUBIT_NUM-1:0]       qiu_i_rs2,
  input  logic                       qiu_i_bcast1,
  input  logic [OPC_W-1:0]           qiu_i_opc1,
  input  logic [OPC_W-1:0]           qiu_i_opc2,
  input  logic                       qiu_i_measure,
  input  logic                       qiu_i_ntp,
  input  logic [TIME_W-1:0]          qiu_i_imm,
  input  logic                       qiu_i_flush,
  output logic                       qiu_o_valid,
  input  logic                       qiu_o_ready,
  output logic [QUBIT_NUM-1:0]       qiu_o_oprand,
  output logic [QUBIT_NUM*OPC_W-1:0] qiu_o_edata,
  output logic [QUBIT_NUM-1:0]       qiu_o_meas,
  output logic [TIME_W-1:0]          qiu_o_tdata,
  output logic [$clog2(DEPTH):0]     qiu_o_level,
  output logic                       qiu_o_conflict
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = QUBIT_NUM * OPC_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [QUBIT_NUM-1:0] op;
    logic [EW-1:0]        ed;
    logic [QUBIT_NUM-1:0] meas;
    logic [TIME_W-1:0]    t;
  } bundle_t;

  // Accumulator for the open timepoint
  logic [QUBIT_NUM-1:0] acc_op;
  logic [EW-1:0]        acc_ed;
  logic [QUBIT_NUM-1:0] acc_meas;
  logic [TIME_W-1:0]    t_cur;
  logic                 flush_pend;
  logic                 conflict;

  // FIFO storage and pointers
  bundle_t              mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          level;

  // Contribution of the presented instruction
  logic [QUBIT_NUM-1:0] m1;
  logic [QUBIT_NUM-1:0] m2;
  logic [QUBIT_NUM-1:0] c_op;
  logic [EW-1:0]        c_ed;
  logic [QUBIT_NUM-1:0] c_meas;
  logic                 self_conf;
  logic [EW-1:0]        merge_ed;

  logic acc_nonempty;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic flush_req;
  logic push_accept;
  logic push_flush;
  logic push;
  logic pop;
  logic hit_conflict;
  bundle_t push_data;
  bundle_t head;

  assign acc_nonempty = (|acc_op) | (|acc_meas);
  assign fifo_full    = (level == FULL_LVL);
  assign fifo_empty   = (level == '0);
  // A closing instruction (or a pending flush) needs a free FIFO slot; a
  // plain merge into an open bundle never pushes and is always accepted.
  assign qiu_i_ready  = ~(fifo_full & (~qiu_i_ntp | flush_pend) & acc_nonempty);
  assign accept       = qiu_i_valid & qiu_i_ready;
  assign flush_req    = qiu_i_flush | flush_pend;
  assign push_accept  = accept & ~qiu_i_ntp & acc_nonempty;
  assign push_flush   = ~accept & flush_req & acc_nonempty & ~fifo_full;
  assign push         = push_accept | push_flush;
  assign pop          = ~fifo_empty & qiu_o_ready;
  assign push_data    = '{op: acc_op, ed: acc_ed, meas: acc_meas, t: t_cur};

  // Decode the instruction into per-qubit masks and opcodes
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    c_op      = '0;
    c_ed      = '0;
    c_meas    = '0;
    self_conf = 1'b0;
    m1        = qiu_i_bcast1 ? {QUBIT_NUM{1'b1}} : qiu_i_rs1;
    m2        = qiu_i_rs2 & ~m1;
    if (qiu_i_measure) begin
      c_meas = qiu_i_rs1;
    end else begin
      c_op      = m1 | m2;
      self_conf = |(m1 & qiu_i_rs2);
      for (int i = 0; i < QUBIT_NUM; i++) begin
        if (m1[i])      c_ed[i*OPC_W +: OPC_W] = qiu_i_opc1;
        else if (m2[i]) c_ed[i*OPC_W +: OPC_W] = qiu_i_opc2;
      end
    end
  end

  // Same-timepoint merge: newly hit qubits take the new opcode
  always_comb begin
    merge_ed = acc_ed;
    for (int i = 0; i < QUBIT_NUM; i++) begin
      if (c_op[i]) merge_ed[i*OPC_W +: OPC_W] = c_ed[i*OPC_W +: OPC_W];
    end
  end

  assign hit_conflict = accept &
                        (self_conf | (qiu_i_ntp & ((|(acc_op & c_op)) | (|(acc_meas & c_meas)))));

  // Accumulator, timestamp, pending-flush and sticky conflict state
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      acc_op     <= '0;
      acc_ed     <= '0;
      acc_meas   <= '0;
      t_cur      <= '0;
      flush_pend <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      conflict <= conflict | hit_conflict;
      if (accept) begin
        if (qiu_i_ntp) begin
          acc_op     <= acc_op | c_op;
          acc_ed     <= merge_ed;
          acc_meas   <= acc_meas | c_meas;
          // A flush arriving with a merge must wait for the next free cycle.
          flush_pend <= flush_req;
        end else begin
          acc_op     <= c_op;
          acc_ed     <= c_ed;
          acc_meas   <= c_meas;
          t_cur      <= t_cur + qiu_i_imm;
          // The push closed the old bundle; only a fresh pulse targets the new one.
          flush_pend <= qiu_i_flush;
        end
      end else if (flush_req) begin
        if (push_flush) begin
          acc_op   <= '0;
          acc_ed   <= '0;
          acc_meas <= '0;
        end
        flush_pend <= acc_nonempty & fifo_full;
      end
    end
  end

  // FIFO payload write
  always_ff @(posedge clk) begin
    // NOTE: payload storage is not reset; outputs are masked while the FIFO is empty.
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign head           = mem[rd_ptr];
  assign qiu_o_valid    = ~fifo_empty;
  assign qiu_o_oprand   = fifo_empty ? '0 : head.op;
  assign qiu_o_edata    = fifo_empty ? '0 : head.ed;
  assign qiu_o_meas     = fifo_empty ? '0 : head.meas;
  assign qiu_o_tdata    = fifo_empty ? '0 : head.t;
  assign qiu_o_level    = level;
  assign qiu_o_conflict = conflict;

endmodule

// File: tb/tb_qpu_exu_qiu_evq.sv
// Directed bench for the QIU event queue with hand-computed expectations.
module tb_qpu_exu_qiu_evq;

  localparam int QN = 12;
  localparam int OW = 5;
  localparam int TW = 32;
  localparam int DP = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           qiu_i_valid;
  logic           qiu_i_ready;
  logic [QN-1:0]  qiu_i_rs1;
  logic [QN-1:0]  qiu_i_rs2;
  logic           qiu_i_bcast1;
  logic [OW-1:0]  qiu_i_opc1;
  logic [OW-1:0]  qiu_i_opc2;
  logic           qiu_i_measure;
  logic           qiu_i_ntp;
  logic [TW-1:0]  qiu_i_imm;
  logic           qiu_i_flush;
  logic           qiu_o_valid;
  logic           qiu_o_ready;
  logic [QN-1:0]  qiu_o_oprand;
  logic [QN*OW-1:0] qiu_o_edata;
  logic [QN-1:0]  qiu_o_meas;
  logic [TW-1:0]  qiu_o_tdata;
  logic [$clog2(DP):0] qiu_o_level;
  logic           qiu_o_conflict;

  int errors = 0;
  int checks = 0;

  qpu_exu_qiu_evq #(.QUBIT_NUM(QN), .OPC_W(OW), .TIME_W(TW), .DEPTH(DP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .qiu_i_valid    (qiu_i_valid),
    .qiu_i_ready    (qiu_i_ready),
    .qiu_i_rs1      (qiu_i_rs1),
    .qiu_i_rs2      (qiu_i_rs2),
    .qiu_i_bcast1   (qiu_i_bcast1),
    .qiu_i_opc1     (qiu_i_opc1),
    .qiu_i_opc2     (qiu_i_opc2),
    .qiu_i_measure  (qiu_i_measure),
    .qiu_i_ntp      (qiu_i_ntp),
    .qiu_i_imm      (qiu_i_imm),
    .qiu_i_flush    (qiu_i_flush),
    .qiu_o_valid    (qiu_o_valid),
    .qiu_o_ready    (qiu_o_ready),
    .qiu_o_oprand   (qiu_o_oprand),
    .qiu_o_edata    (qiu_o_edata),
    .qiu_o_meas     (qiu_o_meas),
    .qiu_o_tdata    (qiu_o_tdata),
    .qiu_o_level    (qiu_o_level),
    .qiu_o_conflict (qiu_o_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    qiu_i_valid   = 1'b0;
    qiu_i_flush   = 1'b0;
    qiu_i_rs1     = '0;
    qiu_i_rs2     = '0;
    qiu_i_bcast1  = 1'b0;
    qiu_i_opc1    = '0;
    qiu_i_opc2    = '0;
    qiu_i_measure = 1'b0;
    qiu_i_ntp     = 1'b1;
    qiu_i_imm     = '0;
  endtask

  task automatic drive(input logic ntp, input logic [TW-1:0] imm, input logic meas,
                       input logic [QN-1:0] rs1, input logic [OW-1:0] opc1,
                       input logic [QN-1:0] rs2, input logic [OW-1:0] opc2);
    qiu_i_valid   = 1'b1;
    qiu_i_flush   = 1'b0;
    qiu_i_bcast1  = 1'b0;
    qiu_i_ntp     = ntp;
    qiu_i_imm     = imm;
    qiu_i_measure = meas;
    qiu_i_rs1     = rs1;
    qiu_i_opc1    = opc1;
    qiu_i_rs2     = rs2;
    qiu_i_opc2    = opc2;
  endtask

  task automatic send(input logic ntp, input logic [TW-1:0] imm, input logic meas,
                      input logic [QN-1:0] rs1, input logic [OW-1:0] opc1,
                      input logic [QN-1:0] rs2, input logic [OW-1:0] opc2);
    drive(ntp, imm, meas, rs1, opc1, rs2, opc2);
    step();
    idle();
  endtask

  task automatic flush_pulse();
    qiu_i_flush = 1'b1;
    step();
    qiu_i_flush = 1'b0;
  endtask

  task automatic pop_one();
    qiu_o_ready = 1'b1;
    step();
    qiu_o_ready = 1'b0;
  endtask

  logic [TW-1:0] exp_t  [4];
  logic [QN-1:0] exp_op [4];

  initial begin
    idle();
    qiu_o_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_o_valid", 64'(qiu_o_valid), 64'd0);
    check("rst_level", 64'(qiu_o_level), 64'd0);
    check("rst_conflict", 64'(qiu_o_conflict), 64'd0);
    check("rst_i_ready", 64'(qiu_i_ready), 64'd1);
    check("rst_tdata", 64'(qiu_o_tdata), 64'd0);

    // First bundle: q0 opc 3, q1 opc 5 at t=10; closing instruction opens t=14
    send(1'b0, 32'd10, 1'b0, 12'h001, 5'd3, 12'h000, 5'd0);
    check("empty_no_push", 64'(qiu_o_level), 64'd0);
    send(1'b1, 32'd0, 1'b0, 12'h000, 5'd0, 12'h002, 5'd5);
    send(1'b0, 32'd4, 1'b0, 12'h010, 5'd7, 12'h000, 5'd0);
    check("b1_valid", 64'(qiu_o_valid), 64'd1);
    check("b1_oprand", 64'(qiu_o_oprand), 64'h003);
    check("b1_edata", 64'(qiu_o_edata), (64'd5 << 5) | 64'd3);
    check("b1_tdata", 64'(qiu_o_tdata), 64'd10);
    check("b1_meas", 64'(qiu_o_meas), 64'd0);
    check("b1_conflict", 64'(qiu_o_conflict), 64'd0);
    pop_one();
    check("b1_popped", 64'(qiu_o_level), 64'd0);

    // Same qubit driven twice in one timepoint: conflict, last opcode wins
    send(1'b1, 32'd0, 1'b0, 12'h004, 5'd1, 12'h000, 5'd0);
    check("no_conflict_yet", 64'(qiu_o_conflict), 64'd0);
    send(1'b1, 32'd0, 1'b0, 12'h004, 5'd2, 12'h000, 5'd0);
    check("conflict_set", 64'(qiu_o_conflict), 64'd1);
    flush_pulse();
    check("b2_oprand", 64'(qiu_o_oprand), 64'h014);
    check("b2_edata", 64'(qiu_o_edata), (64'd7 << 20) | (64'd2 << 10));
    check("b2_tdata", 64'(qiu_o_tdata), 64'd14);
    pop_one();

    // Measurement bundle, closed by flush: t = 14 + 20
    send(1'b0, 32'd20, 1'b1, 12'h00F, 5'd9, 12'h0F0, 5'd9);
    check("meas_no_push", 64'(qiu_o_level), 64'd0);
    flush_pulse();
    check("b3_meas", 64'(qiu_o_meas), 64'h00F);
    check("b3_oprand", 64'(qiu_o_oprand), 64'h000);
    check("b3_tdata", 64'(qiu_o_tdata), 64'd34);
    check("b3_conflict_sticky", 64'(qiu_o_conflict), 64'd1);
    pop_one();

    // Fill the FIFO with o_ready held low
    send(1'b0, 32'd1, 1'b0, 12'h001, 5'd1, 12'h000, 5'd0);
    send(1'b0, 32'd1, 1'b0, 12'h002, 5'd2, 12'h000, 5'd0);
    send(1'b0, 32'd1, 1'b0, 12'h004, 5'd3, 12'h000, 5'd0);
    send(1'b0, 32'd1, 1'b0, 12'h008, 5'd4, 12'h000, 5'd0);
    send(1'b0, 32'd1, 1'b0, 12'h010, 5'd5, 12'h000, 5'd0);
    check("full_level", 64'(qiu_o_level), 64'd4);
    check("full_head_t", 64'(qiu_o_tdata), 64'd35);
    check("full_head_ed", 64'(qiu_o_edata), 64'd1);
    drive(1'b0, 32'd1, 1'b0, 12'h020, 5'd6, 12'h000, 5'd0);
    #1;
    check("full_close_blocked", 64'(qiu_i_ready), 64'd0);
    drive(1'b1, 32'd0, 1'b0, 12'h040, 5'd7, 12'h000, 5'd0);
    #1;
    check("full_merge_ready", 64'(qiu_i_ready), 64'd1);
    step();
    drive(1'b0, 32'd1, 1'b0, 12'h020, 5'd6, 12'h000, 5'd0);
    #1;
    check("full_close_blocked2", 64'(qiu_i_ready), 64'd0);
    qiu_o_ready = 1'b1;
    step();
    qiu_o_ready = 1'b0;
    #1;
    check("after_pop_level", 64'(qiu_o_level), 64'd3);
    check("after_pop_head_t", 64'(qiu_o_tdata), 64'd36);
    check("after_pop_ready", 64'(qiu_i_ready), 64'd1);
    step();
    idle();
    check("refill_level", 64'(qiu_o_level), 64'd4);
    exp_t  = '{32'd36, 32'd37, 32'd38, 32'd39};
    exp_op = '{12'h002, 12'h004, 12'h008, 12'h050};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_t%0d", i), 64'(qiu_o_tdata), 64'(exp_t[i]));
      check($sformatf("drain_op%0d", i), 64'(qiu_o_oprand), 64'(exp_op[i]));
      pop_one();
    end
    check("drained_valid", 64'(qiu_o_valid), 64'd0);

    // Timestamp wrap: t 40 -> 2 -> 1
    send(1'b0, 32'hFFFF_FFDA, 1'b0, 12'h100, 5'd1, 12'h000, 5'd0);
    send(1'b0, 32'hFFFF_FFFF, 1'b0, 12'h200, 5'd1, 12'h000, 5'd0);
    flush_pulse();
    check("wrap_level", 64'(qiu_o_level), 64'd3);
    exp_t = '{32'd40, 32'd2, 32'd1, 32'd0};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_t%0d", i), 64'(qiu_o_tdata), 64'(exp_t[i]));
      pop_one();
    end

    // Reset while full
    for (int i = 0; i < 5; i++) send(1'b0, 32'd1, 1'b0, 12'h001, 5'd1, 12'h000, 5'd0);
    check("pre_rst_level", 64'(qiu_o_level), 64'd4);
    drive(1'b0, 32'd1, 1'b0, 12'h002, 5'd1, 12'h000, 5'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    #1;
    check("mid_rst_valid", 64'(qiu_o_valid), 64'd0);
    check("mid_rst_level", 64'(qiu_o_level), 64'd0);
    check("mid_rst_conflict", 64'(qiu_o_conflict), 64'd0);
    check("mid_rst_ready", 64'(qiu_i_ready), 64'd1);
    // Time restarts from zero and the accumulator is empty after reset
    send(1'b0, 32'd5, 1'b0, 12'h001, 5'd2, 12'h000, 5'd0);
    check("post_rst_no_push", 64'(qiu_o_level), 64'd0);
    flush_pulse();
    check("post_rst_tdata", 64'(qiu_o_tdata), 64'd5);
    check("post_rst_oprand", 64'(qiu_o_oprand), 64'h001);
    check("post_rst_level", 64'(qiu_o_level), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qpu_exu_qiu_evq.md
Name: qpu_exu_qiu_evq

Overview:
Parametrised successor of the combinational QIU event builder. It accepts decoded quantum instructions over a valid/ready handshake and merges all instructions sharing one timepoint into a single event bundle. The bundle holds per-qubit XY opcodes, an operand mask and a measure mask, and is stamped with an accumulated timestamp. Closed bundles are buffered in a DEPTH-entry FIFO that feeds the timing-queue write-back.

Parameters:
QUBIT_NUM, 12, qubit count; width of every mask
OPC_W, 5, XY opcode (waveform address) width per qubit
TIME_W, 32, timestamp width
DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
qiu_i_valid  in  1  instruction valid
qiu_i_ready  out  1  instruction accepted when valid&ready
qiu_i_rs1  in  QUBIT_NUM  target mask for opcode1 (measure mask when measure=1)
qiu_i_rs2  in  QUBIT_NUM  target mask for opcode2
qiu_i_bcast1  in  1  apply opcode1 to all qubits, rs1 ignored
qiu_i_opc1  in  OPC_W  opcode for rs1 targets
qiu_i_opc2  in  OPC_W  opcode for rs2 targets
qiu_i_measure  in  1  measurement instruction
qiu_i_ntp  in  1  1 = same timepoint as previous; 0 = new timepoint
qiu_i_imm  in  TIME_W  time increment, used when ntp=0
qiu_i_flush  in  1  close current bundle (pulse)
qiu_o_valid  out  1  bundle available
qiu_o_ready  in  1  consumer ready
qiu_o_oprand  out  QUBIT_NUM  qubits with an XY event
qiu_o_edata  out  QUBIT_NUM*OPC_W  per-qubit opcode, qubit i at [i*OPC_W +: OPC_W]
qiu_o_meas  out  QUBIT_NUM  measure mask
qiu_o_tdata  out  TIME_W  bundle timestamp
qiu_o_level  out  clog2(DEPTH)+1  FIFO occupancy
qiu_o_conflict  out  1  sticky: qubit driven twice within one timepoint

Behaviour:
- Reset (rst_n low at posedge): FIFO empty, accumulator cleared, t_cur=0, flush_pend=0, conflict=0. All outputs are 0 except qiu_i_ready=1.
- Accumulator state: acc_op, acc_ed, acc_meas, t_cur. acc_nonempty = |acc_op | |acc_meas.
- Per-instruction effect (measure=0): m1 = bcast1 ? all-ones : rs1; m2 = rs2 & ~m1. Qubit i gets opc1 if m1[i], else opc2 if m2[i]. (rs1&rs2) overlap sets conflict; opc1 wins.
- Measure=1: meas contribution = rs1. Opcodes and rs2 are ignored.
- Accept with ntp=1: merge into the accumulator. Any qubit already in acc_op (or acc_meas, for measure) that is hit again sets conflict; the new opcode overwrites. t_cur is unchanged.
- Accept with ntp=0:
  - If acc_nonempty, push {acc, t_cur} to the FIFO this cycle.
  - Accumulator loads only the new instruction's contribution.
  - t_cur <= t_cur + imm, mod 2^TIME_W.
  - If the accumulator was empty, nothing is pushed and time still advances.
- Flush: qiu_i_flush or flush_pend with no accept this cycle, acc_nonempty and FIFO not full -> push and clear the accumulator; t_cur is kept.
  - If the flush cannot complete (accept in same cycle, or FIFO full), flush_pend=1 until it completes.
  - A flush with an empty accumulator clears flush_pend.
  - An accepted ntp=0 push clears flush_pend.
- qiu_i_ready = ~(fifo_full & (~qiu_i_ntp | flush_pend) & acc_nonempty). There is no same-cycle push-on-pop when full.
- FIFO:
  - Outputs come from the head entry.
  - qiu_o_valid = ~empty.
  - Pop on qiu_o_valid & qiu_o_ready.
  - Push and pop in the same cycle keep the level.
  - Pointers wrap mod DEPTH.
- Latency: a bundle appears at qiu_o_valid the cycle after its closing accept/flush, at the earliest.
- conflict is cleared only by reset.

Test Plan:
- Reset, then ntp=0 imm=10 X(opc1=3) on rs1=0x001; then ntp=1 opc2=5 on rs2=0x002; then ntp=0 imm=4 -> one bundle: oprand=0x003, edata q0=3 q1=5, tdata=10; t_cur=14.
- ntp=1 with rs1=0x004 twice in one timepoint (opc 1 then 2) -> conflict=1 stays high, bundle edata q2=2.
- Measure rs1=0x00F, ntp=0 imm=20, then flush -> bundle meas=0x00F, oprand=0, tdata=t_prev+20.
- Hold qiu_o_ready=0, close 4 bundles (DEPTH=4) -> level=4; a 5th closing ntp=0 sees ready=0; an ntp=1 merge is still accepted. Raising o_ready for one cycle pops one entry, and the pending instruction is accepted the next cycle.
- imm=0xFFFF_FFFF with t_cur=2 -> t_cur=1, no error (wrap).
- Assert rst_n low mid-stream with a full FIFO -> next cycle o_valid=0, level=0, conflict=0, i_ready=1.
